// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - immediate packer: inserts a 64-bit immediate into an RV64 instruction template
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   request handshake
//   ins_type              format code: itype=0 stype=1 btype=2 utype=3 jtype=4 ntype=5 rtype=6, 7 illegal
//   imm                   immediate (byte offset for btype/jtype)
//   base                  template instruction supplying the non-immediate fields
//   out_valid / out_ready result handshake
//   ins                   packed instruction
//   range_err             imm not representable in ins_type, or ins_type illegal
//   align_err             imm[0] set for btype/jtype
//   err_clr               synchronous clear of err_count
//   err_count             saturating count of delivered results with any error bit set
module imm_pack #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ins_type,
    input  logic [63:0]      imm,
    input  logic [31:0]      base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      ins,
    output logic             range_err,
    output logic             align_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [2:0] T_I = 3'd0;
    localparam logic [2:0] T_S = 3'd1;
    localparam logic [2:0] T_B = 3'd2;
    localparam logic [2:0] T_U = 3'd3;
    localparam logic [2:0] T_J = 3'd4;
    localparam logic [2:0] T_N = 3'd5;
    localparam logic [2:0] T_R = 3'd6;

    // Upper bits must all equal the sign bit for the value to fit the field.
    logic fits_11, fits_12, fits_20, fits_31;
    assign fits_11 = (&imm[63:11]) | ~(|imm[63:11]);
    assign fits_12 = (&imm[63:12]) | ~(|imm[63:12]);
    assign fits_20 = (&imm[63:20]) | ~(|imm[63:20]);
    assign fits_31 = (&imm[63:31]) | ~(|imm[63:31]);

    logic range_d, align_d;
    always_comb begin
        range_d = 1'b0;
        align_d = 1'b0;
        case (ins_type)
            T_I, T_S: range_d = ~fits_11;
            T_B: begin
                range_d = ~fits_12;
                align_d = imm[0];
            end
            T_U: range_d = (imm[11:0] != 12'd0) | ~fits_31;
            T_J: begin
                range_d = ~fits_20;
                align_d = imm[0];
            end
            T_N, T_R: range_d = 1'b0;
            default:  range_d = 1'b1;
        endcase
    end

    // Stage 1: request plus its checks. Only imm[31:0] is ever packed.
    logic        s1_valid;
    logic [2:0]  s1_type;
    logic [31:0] s1_imm;
    logic [31:0] s1_base;
    logic        s1_range, s1_align;

    logic s1_load, s2_load;
    assign s2_load  = ~out_valid | out_ready;
    assign s1_load  = ~s1_valid | s2_load;
    assign in_ready = s1_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_type  <= 3'd0;
            s1_imm   <= 32'd0;
            s1_base  <= 32'd0;
            s1_range <= 1'b0;
            s1_align <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_type  <= ins_type;
                s1_imm   <= imm[31:0];
                s1_base  <= base;
                s1_range <= range_d;
                s1_align <= align_d;
            end
        end
    end

    // Packing happens regardless of errors, using the truncated bits.
    logic [31:0] packed_ins;
    always_comb begin
        packed_ins = s1_base;
        case (s1_type)
            T_I: packed_ins[31:20] = s1_imm[11:0];
            T_S: begin
                packed_ins[31:25] = s1_imm[11:5];
                packed_ins[11:7]  = s1_imm[4:0];
            end
            T_B: begin
                packed_ins[31]    = s1_imm[12];
                packed_ins[30:25] = s1_imm[10:5];
                packed_ins[11:8]  = s1_imm[4:1];
                packed_ins[7]     = s1_imm[11];
            end
            T_U: packed_ins[31:12] = s1_imm[31:12];
            T_J: begin
                packed_ins[31]    = s1_imm[20];
                packed_ins[30:21] = s1_imm[10:1];
                packed_ins[20]    = s1_imm[11];
                packed_ins[19:12] = s1_imm[19:12];
            end
            default: packed_ins = s1_base;
        endcase
    end

    // Stage 2: registers drive the outputs directly, so they hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ins       <= 32'd0;
            range_err <= 1'b0;
            align_err <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                ins       <= packed_ins;
                range_err <= s1_range;
                align_err <= s1_align;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (out_valid && out_ready && (range_err || align_err) && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule
